// File: rtl/frame_draw_sequencer_if.sv
// Sprite ROM read port and frame buffer write port shared between the
// frame draw sequencer (master) and the ROM / frame buffer side (slave).
interface frame_draw_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [16:0]       fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic              fb_we;
    logic              fb_ready;

    modport master (
        output rom_addr,
        input  rom_data,
        output fb_addr,
        output fb_data,
        output fb_we,
        input  fb_ready
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  fb_addr,
        input  fb_data,
        input  fb_we,
        output fb_ready
    );
endinterface

// File: rtl/frame_draw_sequencer.sv
// Raster-order pixel scheduler: arbitrates one sprite ROM read port across
// object layers and writes one palette index per pixel to the frame buffer.
//
// state   | meaning
// IDLE    | waiting for frame_start
// SCAN    | sample layer_hit, pick highest-priority layer
// READ    | ROM address presented
// WAIT    | ROM pipeline delay
// CAPTURE | latch ROM data (transparent -> background)
// WRITE   | fb_we asserted until fb_ready, then advance pixel
// DONE    | one-cycle frame completion pulse
module frame_draw_sequencer #(
    parameter int                 H_RES           = 320,
    parameter int                 V_RES           = 240,
    parameter int                 NUM_LAYERS      = 4,
    parameter int                 ADDR_W          = 16,
    parameter int                 DATA_W          = 4,
    parameter logic [DATA_W-1:0]  TRANSPARENT_IDX = '0,
    parameter logic [DATA_W-1:0]  BG_IDX          = 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_start,
    output logic [8:0]                   PixelX,
    output logic [8:0]                   PixelY,
    input  logic [NUM_LAYERS-1:0]        layer_hit,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    frame_draw_sequencer_if.master       bus,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);
    localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_READ, S_WAIT, S_CAPTURE, S_WRITE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        px_q, px_d, py_q, py_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [16:0]       fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0] fb_data_q, fb_data_d;
    logic              overrun_q, overrun_d;
    logic [SEL_W-1:0]  sel;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            px_q       <= '0;
            py_q       <= '0;
            rom_addr_q <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            py_q       <= py_d;
            rom_addr_q <= rom_addr_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        py_d       = py_q;
        rom_addr_d = rom_addr_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        overrun_d  = overrun_q | (frame_start && (state_q != S_IDLE));

        // Descending walk so the lowest set index (highest priority) wins.
        sel = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i]) sel = SEL_W'(i);
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    px_d      = '0;
                    py_d      = '0;
                    fb_addr_d = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (|layer_hit) begin
                    rom_addr_d = layer_addr[sel*ADDR_W +: ADDR_W];
                    state_d    = S_READ;
                end else begin
                    fb_data_d = BG_IDX;
                    state_d   = S_WRITE;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_CAPTURE;
            S_CAPTURE: begin
                fb_data_d = (bus.rom_data == TRANSPARENT_IDX) ? BG_IDX : bus.rom_data;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                if (bus.fb_ready) begin
                    fb_addr_d = fb_addr_q + 17'd1;
                    state_d   = S_SCAN;
                    if (px_q == 9'(H_RES - 1)) begin
                        px_d = '0;
                        if (py_q == 9'(V_RES - 1)) state_d = S_DONE;
                        else                       py_d    = py_q + 9'd1;
                    end else begin
                        px_d = px_q + 9'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PixelX       = px_q;
        PixelY       = py_q;
        bus.rom_addr = rom_addr_q;
        bus.fb_addr  = fb_addr_q;
        bus.fb_data  = fb_data_q;
        bus.fb_we    = (state_q == S_WRITE);
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        overrun      = overrun_q;
    end
endmodule
